// File: rtl/qdr_req_buffer.sv
// Fabric-side request buffer feeding the QDR sniffer slave port: show-ahead FIFO,
// outstanding-read tracking and sticky error flags. Define QDR_REQ_BUF_STATS_EN for the stall counter.
module qdr_req_buffer #(
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 qdr_clk,
    input  logic                 qdr_rst_n,
    input  logic [31:0]          user_addr,
    input  logic                 user_wr_strb,
    input  logic [35:0]          user_wr_data,
    input  logic [3:0]           user_wr_be,
    input  logic                 user_rd_strb,
    output logic [35:0]          user_rd_data,
    output logic                 user_rd_dvld,
    output logic                 user_almost_full,
    output logic                 user_rd_pending,
    output logic                 err_overflow,
    output logic                 err_proto,
    input  logic                 err_clr,
    output logic [31:0]          slave_addr,
    output logic                 slave_wr_strb,
    output logic [35:0]          slave_wr_data,
    output logic [3:0]           slave_wr_be,
    output logic                 slave_rd_strb,
    input  logic [35:0]          slave_rd_data,
    input  logic                 slave_rd_dvld,
    input  logic                 slave_ack,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]          PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0]          AF_LEVEL = (AW+1)'(DEPTH - 2);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    typedef struct packed {
        logic        rnw;
        logic [31:0] addr;
        logic [35:0] data;
        logic [3:0]  be;
    } entry_t;

    entry_t               mem [DEPTH];
    entry_t               head;
    entry_t               push_entry;
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [AW:0]          occ;
    logic [AW:0]          occ_next;
    logic                 empty;
    logic                 full;
    logic                 valid;
    logic                 pop;
    logic                 push_req;
    logic                 push_ok;
    logic                 overflow_set;
    logic                 proto_set;
    logic                 rd_inc;
    logic                 rd_dec;
    logic [CNT_WIDTH-1:0] rd_cnt;
    logic [CNT_WIDTH-1:0] rd_cnt_next;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid = !empty;
    assign pop   = valid & slave_ack;

    // A write wins over a simultaneous read; the read is dropped and flagged.
    assign push_req     = user_wr_strb | user_rd_strb;
    assign push_ok      = push_req & (!full | pop);
    assign overflow_set = push_req & full & !pop;
    assign proto_set    = user_wr_strb & user_rd_strb;
    assign push_entry   = {~user_wr_strb, user_addr, user_wr_data, user_wr_be};

    assign head          = mem[rd_ptr[AW-1:0]];
    assign slave_wr_strb = valid & !head.rnw;
    assign slave_rd_strb = valid & head.rnw;
    assign slave_addr    = valid ? head.addr : '0;
    assign slave_wr_data = valid ? head.data : '0;
    assign slave_wr_be   = valid ? head.be   : '0;

    assign occ    = wr_ptr - rd_ptr;
    assign rd_inc = slave_rd_strb & slave_ack;
    assign rd_dec = slave_rd_dvld & (rd_cnt != '0);

    always_comb begin
        occ_next = occ;
        if (push_ok && !pop) begin
            occ_next = occ + PTR_ONE;
        end else if (!push_ok && pop) begin
            occ_next = occ - PTR_ONE;
        end
    end

    always_comb begin
        rd_cnt_next = rd_cnt;
        if (rd_inc && !rd_dec && (rd_cnt != CNT_MAX)) begin
            rd_cnt_next = rd_cnt + CNT_ONE;
        end else if (rd_dec && !rd_inc) begin
            rd_cnt_next = rd_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge qdr_clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    // Status outputs are registered from next-state values so they never lag.
    always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
        if (!qdr_rst_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            rd_cnt           <= '0;
            user_almost_full <= 1'b0;
            user_rd_pending  <= 1'b0;
            user_rd_data     <= '0;
            user_rd_dvld     <= 1'b0;
            err_overflow     <= 1'b0;
            err_proto        <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            rd_cnt           <= rd_cnt_next;
            user_almost_full <= (occ_next >= AF_LEVEL);
            user_rd_pending  <= (rd_cnt_next != '0);
            user_rd_data     <= slave_rd_data;
            user_rd_dvld     <= slave_rd_dvld;
            if (overflow_set) begin
                err_overflow <= 1'b1;
            end else if (err_clr) begin
                err_overflow <= 1'b0;
            end
            if (proto_set) begin
                err_proto <= 1'b1;
            end else if (err_clr) begin
                err_proto <= 1'b0;
            end
        end
    end

`ifdef QDR_REQ_BUF_STATS_EN
    logic [CNT_WIDTH-1:0] stall_q;

    always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
        if (!qdr_rst_n) begin
            stall_q <= '0;
        end else if (err_clr) begin
            stall_q <= '0;
        end else if (valid && !slave_ack && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + CNT_ONE;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_qdr_req_buffer.sv
// Scoreboard bench for qdr_req_buffer: directed requests queue expected slave issues and
// read returns; a negedge monitor pops and compares whenever the DUT issues or returns.
module tb_qdr_req_buffer;

    localparam int DEPTH     = 16;
    localparam int CNT_WIDTH = 8;

    typedef struct packed {
        logic        rnw;
        logic [31:0] addr;
        logic [35:0] data;
        logic [3:0]  be;
    } req_t;

    logic                 qdr_clk       = 1'b0;
    logic                 qdr_rst_n     = 1'b0;
    logic [31:0]          user_addr     = '0;
    logic                 user_wr_strb  = 1'b0;
    logic [35:0]          user_wr_data  = '0;
    logic [3:0]           user_wr_be    = '0;
    logic                 user_rd_strb  = 1'b0;
    logic [35:0]          user_rd_data;
    logic                 user_rd_dvld;
    logic                 user_almost_full;
    logic                 user_rd_pending;
    logic                 err_overflow;
    logic                 err_proto;
    logic                 err_clr       = 1'b0;
    logic [31:0]          slave_addr;
    logic                 slave_wr_strb;
    logic [35:0]          slave_wr_data;
    logic [3:0]           slave_wr_be;
    logic                 slave_rd_strb;
    logic [35:0]          slave_rd_data = '0;
    logic                 slave_rd_dvld = 1'b0;
    logic                 slave_ack     = 1'b0;
    logic [CNT_WIDTH-1:0] stall_cnt;

    int          vectors     = 0;
    int          miscompares = 0;
    req_t        exp_q[$];
    logic [35:0] rd_exp_q[$];
    req_t        mon_got;
    req_t        mon_exp;
    logic [35:0] mon_rd;

    always #5 qdr_clk = ~qdr_clk;

    qdr_req_buffer #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .qdr_clk          (qdr_clk),
        .qdr_rst_n        (qdr_rst_n),
        .user_addr        (user_addr),
        .user_wr_strb     (user_wr_strb),
        .user_wr_data     (user_wr_data),
        .user_wr_be       (user_wr_be),
        .user_rd_strb     (user_rd_strb),
        .user_rd_data     (user_rd_data),
        .user_rd_dvld     (user_rd_dvld),
        .user_almost_full (user_almost_full),
        .user_rd_pending  (user_rd_pending),
        .err_overflow     (err_overflow),
        .err_proto        (err_proto),
        .err_clr          (err_clr),
        .slave_addr       (slave_addr),
        .slave_wr_strb    (slave_wr_strb),
        .slave_wr_data    (slave_wr_data),
        .slave_wr_be      (slave_wr_be),
        .slave_rd_strb    (slave_rd_strb),
        .slave_rd_data    (slave_rd_data),
        .slave_rd_dvld    (slave_rd_dvld),
        .slave_ack        (slave_ack),
        .stall_cnt        (stall_cnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one request for one cycle; accept says whether the buffer should keep it.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                 input logic [35:0] data, input logic [3:0] be, input logic accept);
        user_wr_strb = wr;
        user_rd_strb = rd;
        user_addr    = addr;
        user_wr_data = data;
        user_wr_be   = be;
        if (accept) begin
            exp_q.push_back('{rnw: ~wr, addr: addr, data: data, be: be});
        end
        @(posedge qdr_clk);
        #1;
        user_wr_strb = 1'b0;
        user_rd_strb = 1'b0;
    endtask

    task automatic returnData(input logic [35:0] d);
        slave_rd_dvld = 1'b1;
        slave_rd_data = d;
        rd_exp_q.push_back(d);
        @(posedge qdr_clk);
        #1;
        slave_rd_dvld = 1'b0;
        slave_rd_data = '0;
        checkOutput("rd_dvld_latency", 64'(user_rd_dvld), 64'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge qdr_clk);
            #1;
        end
    endtask

    // Monitor: every consumed head and every read return is matched against the scoreboard.
    always @(negedge qdr_clk) begin
        if (qdr_rst_n && slave_ack && (slave_wr_strb || slave_rd_strb)) begin
            mon_got = '{rnw: slave_rd_strb, addr: slave_addr, data: slave_wr_data, be: slave_wr_be};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL issue: got %h, expected no request", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    miscompares++;
                    $display("[TB] FAIL issue: got %h, expected %h", mon_got, mon_exp);
                end
            end
        end
        if (user_rd_dvld) begin
            vectors++;
            if (rd_exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL rd_return: got %h, expected no return", user_rd_data);
            end else begin
                mon_rd = rd_exp_q.pop_front();
                if (user_rd_data !== mon_rd) begin
                    miscompares++;
                    $display("[TB] FAIL rd_return: got %h, expected %h", user_rd_data, mon_rd);
                end
            end
        end
    end

    initial begin
        #100000;
        miscompares++;
        $display("[TB] FAIL timeout: simulation did not complete, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        @(posedge qdr_clk);
        #1;
        $display("[TB] reset values");
        checkOutput("rst_slave_wr_strb", 64'(slave_wr_strb), 64'd0);
        checkOutput("rst_slave_rd_strb", 64'(slave_rd_strb), 64'd0);
        checkOutput("rst_slave_addr", 64'(slave_addr), 64'd0);
        checkOutput("rst_flags", 64'({user_almost_full, user_rd_pending, err_overflow, err_proto, user_rd_dvld}), 64'd0);
        checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        idle(1);
        qdr_rst_n = 1'b1;
        idle(1);

        $display("[TB] back-to-back writes");
        slave_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h10 + 32'(i), 36'h1_0000_0100 + 36'(i), 4'(i + 1), 1'b1);
            if (i == 0) begin
                checkOutput("first_issue_strb", 64'(slave_wr_strb), 64'd1);
                checkOutput("first_issue_addr", 64'(slave_addr), 64'h10);
            end
        end
        idle(2);
        checkOutput("b2b_drained", 64'(exp_q.size()), 64'd0);
        checkOutput("b2b_errors", 64'({err_overflow, err_proto}), 64'd0);

        $display("[TB] held head");
        slave_ack = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h40, 36'h0, 4'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checkOutput("held_rd_strb", 64'(slave_rd_strb), 64'd1);
            checkOutput("held_addr", 64'(slave_addr), 64'h40);
            if (k < 2) idle(1);
        end
        idle(1);
        slave_ack = 1'b1;
`ifdef QDR_REQ_BUF_STATS_EN
        checkOutput("stall_cnt", 64'(stall_cnt), 64'd3);
`endif
        idle(1);
        checkOutput("held_popped", 64'(slave_rd_strb), 64'd0);
        checkOutput("pending_after_issue", 64'(user_rd_pending), 64'd1);
        returnData(36'hA_BCDE_0040);
        checkOutput("pending_after_return", 64'(user_rd_pending), 64'd0);

        $display("[TB] overflow");
        slave_ack = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h100 + 32'(i), 36'h2_0000_0000 + 36'(i), 4'hF, i < DEPTH);
            if (i == 12) checkOutput("af_at_13", 64'(user_almost_full), 64'd0);
            if (i == 13) checkOutput("af_at_14", 64'(user_almost_full), 64'd1);
            if (i == 15) checkOutput("ovf_at_full", 64'(err_overflow), 64'd0);
            if (i == 16) checkOutput("ovf_dropped", 64'(err_overflow), 64'd1);
        end
        slave_ack = 1'b1;
        idle(DEPTH + 1);
        checkOutput("ovf_drained", 64'(exp_q.size()), 64'd0);
        checkOutput("ovf_empty", 64'({slave_wr_strb, user_almost_full}), 64'd0);
        checkOutput("ovf_still_set", 64'(err_overflow), 64'd1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        checkOutput("ovf_cleared", 64'(err_overflow), 64'd0);

        $display("[TB] full with simultaneous pop");
        slave_ack = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h200 + 32'(i), 36'h3_0000_0000 + 36'(i), 4'h5, 1'b1);
        end
        checkOutput("full_af", 64'(user_almost_full), 64'd1);
        slave_ack = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h300, 36'h3_1111_1111, 4'hA, 1'b1);
        slave_ack = 1'b0;
        checkOutput("full_pop_no_ovf", 64'(err_overflow), 64'd0);
        checkOutput("full_pop_af", 64'(user_almost_full), 64'd1);
        applyStimulus(1'b1, 1'b0, 32'h301, 36'h3_2222_2222, 4'hB, 1'b0);
        checkOutput("still_full_ovf", 64'(err_overflow), 64'd1);
        slave_ack = 1'b1;
        idle(DEPTH + 1);
        checkOutput("full_drained", 64'(exp_q.size()), 64'd0);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;

        $display("[TB] read tracking");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h500 + 32'(i), 36'h0, 4'h0, 1'b1);
        end
        idle(2);
        checkOutput("pending_3", 64'(user_rd_pending), 64'd1);
        applyStimulus(1'b0, 1'b1, 32'h503, 36'h0, 4'h0, 1'b1);
        returnData(36'h5_0000_0001);
        returnData(36'h5_0000_0002);
        returnData(36'h5_0000_0003);
        checkOutput("pending_1", 64'(user_rd_pending), 64'd1);
        returnData(36'h5_0000_0004);
        checkOutput("pending_0", 64'(user_rd_pending), 64'd0);

        $display("[TB] protocol error and reset");
        slave_ack = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h600, 36'h6_0000_0600, 4'hC, 1'b1);
        checkOutput("proto_flag", 64'(err_proto), 64'd1);
        checkOutput("proto_wr_kept", 64'({slave_wr_strb, slave_rd_strb}), 64'b10);
        checkOutput("proto_addr", 64'(slave_addr), 64'h600);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h600 + 32'(i), 36'h6_0000_0600 + 36'(i), 4'hC, 1'b1);
        end
        slave_ack = 1'b1;
        idle(1);
        #2;
        qdr_rst_n = 1'b0;
        #1;
        exp_q.delete();
        checkOutput("midrst_strb", 64'({slave_wr_strb, slave_rd_strb}), 64'd0);
        checkOutput("midrst_addr", 64'(slave_addr), 64'd0);
        checkOutput("midrst_flags", 64'({err_proto, err_overflow, user_almost_full, user_rd_pending}), 64'd0);
        @(posedge qdr_clk);
        #1;
        qdr_rst_n = 1'b1;
        idle(1);
        checkOutput("post_rst_empty", 64'(slave_wr_strb), 64'd0);
        returnData(36'h7_0000_00FF);
        checkOutput("post_rst_uncounted", 64'(user_rd_pending), 64'd0);
        applyStimulus(1'b1, 1'b0, 32'h700, 36'h7_0000_0700, 4'h9, 1'b1);
        idle(3);
        checkOutput("final_issue_q", 64'(exp_q.size()), 64'd0);
        checkOutput("final_rd_q", 64'(rd_exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
